// File: rtl/stream_arb_mux_pkg.sv
// stream_arb_mux_pkg: shared mode encoding and index-width helper for stream_arb_mux
package stream_arb_mux_pkg;
  typedef enum logic {MODE_SEL = 1'b0, MODE_RR = 1'b1} mode_t;
  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction
endpackage

// File: rtl/rr_arbiter.sv
// rr_arbiter: combinational one-hot round-robin grant, searching cyclically from ptr+1
module rr_arbiter
  import stream_arb_mux_pkg::*;
#(
  parameter int N_CH = 4
) (
  input  logic [N_CH-1:0]         req,
  input  logic [idx_w(N_CH)-1:0]  ptr,
  output logic [N_CH-1:0]         grant
);
  // Walk from the farthest candidate back to ptr+1 so the nearest requester wins.
  always_comb begin
    grant = '0;
    for (int k = N_CH; k >= 1; k--)
      if (req[(int'(ptr) + k) % N_CH]) begin
        grant = '0;
        grant[(int'(ptr) + k) % N_CH] = 1'b1;
      end
  end
endmodule

// File: rtl/stream_arb_mux.sv
// stream_arb_mux: registered N-channel valid/ready mux, explicit select or round-robin.
// Round-robin mode and its ptr register exist only when STREAM_ARB_MUX_RR_EN is defined.
module stream_arb_mux
  import stream_arb_mux_pkg::*;
#(
  parameter int N_CH = 4,
  parameter int W    = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     mode,
  input  logic [$clog2(N_CH)-1:0]  sel,
  input  logic [N_CH-1:0]          in_valid,
  input  logic [N_CH*W-1:0]        in_data,
  output logic [N_CH-1:0]          in_ready,
  output logic                     out_valid,
  output logic [W-1:0]             out_data,
  output logic [$clog2(N_CH)-1:0]  out_ch,
  input  logic                     out_ready
);
  localparam int IW = idx_w(N_CH);
  localparam int NP = 1 << IW;
  logic            load;
  logic [N_CH-1:0] grant, sel_grant;
  logic [NP-1:0]   v_ext, g_ext;
  logic [IW-1:0]   gidx;
  logic [W-1:0]    gdata;
  assign load = !out_valid || out_ready;
  // Padding valid to a power of two makes out-of-range sel select a constant-zero lane.
  assign v_ext = NP'(in_valid);
  always_comb begin
    g_ext = '0;
    g_ext[sel] = v_ext[sel];
  end
  assign sel_grant = g_ext[N_CH-1:0];
`ifdef STREAM_ARB_MUX_RR_EN
  logic [IW-1:0]   ptr;
  logic [N_CH-1:0] rr_grant;
  rr_arbiter #(.N_CH(N_CH)) u_rr (.req(in_valid), .ptr(ptr), .grant(rr_grant));
  assign grant = (mode == MODE_RR) ? rr_grant : sel_grant;
  always_ff @(posedge clk or posedge rst)
    if (rst) ptr <= IW'(N_CH - 1);
    else if (load && |grant && mode == MODE_RR) ptr <= gidx;
`else
  logic unused_mode;
  assign unused_mode = mode;
  assign grant = sel_grant;
`endif
  assign in_ready = grant & {N_CH{load}};
  always_comb begin
    gidx  = '0;
    gdata = '0;
    for (int i = 0; i < N_CH; i++) begin
      gidx  = grant[i] ? IW'(i) : gidx;
      gdata = gdata | (in_data[i*W +: W] & {W{grant[i]}});
    end
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      out_ch    <= '0;
    end else if (load) begin
      out_valid <= |grant;
      if (|grant) begin
        out_data <= gdata;
        out_ch   <= gidx;
      end
    end
endmodule

// File: doc/stream_arb_mux.md
# stream_arb_mux

Registered N-channel, W-bit valid/ready stream multiplexer. It is the sequential, parametrised successor of the team's fixed 4:1 combinational data muxes. Each cycle it selects one input channel, either by an explicit select or by round-robin arbitration, and moves that channel's beat into a single output register. It sits between multiple producers and one shared consumer, for example several request sources feeding one processing pipeline.

## Interface
- `N_CH`, default 4: number of input channels; must be ≥ 2.
- `W`, default 8: data width per channel in bits; must be ≥ 1.
- `clk` input 1: clock; all state updates on the rising edge.
- `rst` input 1: asynchronous, active-high reset.
- `mode` input 1: 0 = SEL (explicit select), 1 = RR (round-robin).
- `sel` input `$clog2(N_CH)`: channel index, used only in SEL mode.
- `in_valid` input `N_CH`: per-channel valid.
- `in_data` input `N_CH*W`: channel i occupies bits `[i*W +: W]`.
- `in_ready` output `N_CH`: per-channel ready; combinational.
- `out_valid` output 1: output register holds a beat.
- `out_data` output W: registered data.
- `out_ch` output `$clog2(N_CH)`: index of the channel the held beat came from.
- `out_ready` input 1: consumer accepts the beat.

## Operation
- `load = !out_valid || out_ready`. This gives a single-stage register with full throughput: one beat per cycle when `out_ready` is held high.
- Grant is one-hot over channels, computed combinationally.
  - SEL mode: grant is `sel` only if `in_valid[sel]` is high. If `sel ≥ N_CH`, there is no grant.
  - RR mode: grant goes to the first valid channel searching cyclically from `ptr+1`.
- `in_ready[i] = grant[i] && load`. At most one `in_ready` bit is high in any cycle.
- Input transfer on channel i: `in_valid[i] && in_ready[i]`.
  - Next cycle: `out_data` = that channel's data, `out_ch` = i, `out_valid` = 1.
- Output transfer (`out_valid && out_ready`) with no input transfer in the same cycle: `out_valid` goes to 0. `out_data` and `out_ch` hold their values.
- Output transfer and input transfer in the same cycle: the register is replaced by the new beat, with no bubble.
- `ptr` is the last granted channel. It updates to i only on an input transfer in RR mode; it is untouched in SEL mode.
- A `mode` or `sel` change takes effect the same cycle, since the grant is combinational. A beat already held in the output register is unaffected.
- No valid input and `load` high: `out_valid` goes to 0 after any pending output transfer. No state changes except the output drain.
- Producers must keep `in_valid` and `in_data` stable until transfer. The mux does not check this.

## Timing
- Latency is 1 cycle from input transfer to `out_valid`.
- Throughput is 1 beat per cycle. In RR mode, each channel that is continuously valid gets at least 1 beat in every `N_CH` transfers.
- Reset, asynchronous:
  - `out_valid` = 0, `out_data` = 0, `out_ch` = 0.
  - `ptr` = `N_CH-1`, so channel 0 has first priority after reset.
  - `in_ready` follows combinationally, so with `out_valid` = 0 it can be high during reset. Producers must not count transfers while `rst` is high.
- Reset mid-operation drops any held beat with no output transfer.
- Backpressure: when `out_ready` = 0 and `out_valid` = 1, all `in_ready` bits are 0 and `ptr` is frozen.

## Configuration
- `STREAM_ARB_MUX_RR_EN` defined:
  - RR mode and the `ptr` register are compiled in.
  - `mode` behaves as described above.
- `STREAM_ARB_MUX_RR_EN` undefined:
  - No `ptr` register and no round-robin logic.
  - The `mode` port is kept but ignored; the block always behaves as in SEL mode.

## Structure
- Package `stream_arb_mux_pkg` holds:
  - the `mode_t` enum: `MODE_SEL` = 1'b0, `MODE_RR` = 1'b1;
  - the `clog2`-based index width helper.
- Sub-module `rr_arbiter` (`N_CH` parameter):
  - inputs: `req[N_CH]` and `ptr`;
  - output: one-hot `grant`;
  - purely combinational; `ptr` itself is stored in the parent.
- Top level holds the grant mux (SEL or RR), the `in_ready` fan-out, the data select (one-hot AND-OR), the output register and `ptr`.

## Test plan
- **Reset state:** assert `rst` mid-stream with `out_valid` = 1. Required: `out_valid` = 0, `out_data` = 0, `out_ch` = 0 immediately, without waiting for a clock edge.
- **SEL mode:** `N_CH` = 4, W = 8, `sel` = 2, all channels valid, `in_data[2]` = 0xA5, `out_ready` = 1. Required: only `in_ready[2]` high; next cycle `out_data` = 0xA5, `out_ch` = 2.
- **SEL invalid channel:** `sel` = 1 with `in_valid[1]` = 0. Required: all `in_ready` = 0 and `out_valid` drops to 0 after the held beat drains.
- **RR fairness:** all 4 channels valid continuously for 8 cycles after reset, `out_ready` = 1. Required: `out_ch` sequence 0,1,2,3,0,1,2,3.
- **RR skip:** only channels 1 and 3 valid. Required: `out_ch` alternates 1,3,1,3 with no bubbles.
- **Backpressure:** `out_ready` = 0 for 3 cycles while `out_valid` = 1. Required: `out_data` and `out_ch` stable, all `in_ready` = 0, `ptr` frozen; when `out_ready` rises, the next beat is loaded in the same cycle, with no lost or duplicated beats (checked by a scoreboard).
